reg_dump_reader: RTL

Debug/readout engine for the 32×32 CPU register file. On a start pulse it walks register addresses 0..NUM_REGS-1 through one register-file read port and streams each (address, data) pair out over a valid/ready interface. It also accumulates an XOR checksum of all streamed words. It sits between the register file's spare read port and the lab's debug/trace sink.

---
 rtl/reg_dump_pkg.sv | 7 +
 rtl/reg_dump_reader_if.sv | 24 ++
 rtl/reg_dump_reader.sv | 77 +++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: state encoding and default sizes shared by the register dump reader.
package reg_dump_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if: control, register-file read port and dump stream of the register dump reader.
interface reg_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start_i;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W-1:0] rs_addr_o;
    logic [DATA_W-1:0] rs_data_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [ADDR_W-1:0] dump_addr_o;
    logic [DATA_W-1:0] dump_data_o;
    logic [DATA_W-1:0] checksum_o;
    modport master (
        input  start_i, rs_data_i, dump_ready_i,
        output busy_o, done_o, rs_addr_o, dump_valid_o, dump_addr_o, dump_data_o, checksum_o
    );
    modport slave (
        output start_i, rs_data_i, dump_ready_i,
        input  busy_o, done_o, rs_addr_o, dump_valid_o, dump_addr_o, dump_data_o, checksum_o
    );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file through one read port and streams (addr, data) pairs
// with an XOR checksum of every accepted word.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SKIP_ZERO = 0
) (
    input logic clk_i,
    input logic rst_i,
    reg_dump_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] first_addr = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] last_addr = ADDR_W'(NUM_REGS - 1);
    state_t            state;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rs_addr;
    logic              valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic [DATA_W-1:0] checksum;
    // rs_addr doubles as the walk index, so it only moves on start or advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rs_addr   <= '0;
            valid     <= 1'b0;
            dump_addr <= '0;
            dump_data <= '0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start_i) begin
                    rs_addr  <= first_addr;
                    checksum <= '0;
                    busy     <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    dump_data <= bus.rs_data_i;
                    dump_addr <= rs_addr;
                    valid     <= 1'b1;
                    state     <= SEND;
                end
                SEND: if (bus.dump_ready_i) begin
                    checksum <= checksum ^ dump_data;
                    valid    <= 1'b0;
                    if (rs_addr == last_addr) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rs_addr <= rs_addr + 1'b1;
                        state   <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.rs_addr_o    = rs_addr;
    assign bus.dump_valid_o = valid;
    assign bus.dump_addr_o  = dump_addr;
    assign bus.dump_data_o  = dump_data;
    assign bus.checksum_o   = checksum;
endmodule
